// File: rtl/oven_pkg.sv
// Shared types for the oven cook controller: FSM encoding, BCD limits and
// the mm:ss time word held by the time register.
package oven_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        COOK  = 3'd1,
        PAUSE = 3'd2,
        DONE  = 3'd3
    } oven_state_t;

    typedef enum logic [1:0] {
        OP_HOLD = 2'd0,
        OP_ZERO = 2'd1,
        OP_ADD  = 2'd2,
        OP_SUB  = 2'd3
    } bcd_op_t;

    localparam logic [3:0] ONES_MAX = 4'd9;
    localparam logic [2:0] TENS_MAX = 3'd5;

    typedef struct packed {
        logic [2:0] min_tens;
        logic [3:0] min_ones;
        logic [2:0] sec_tens;
        logic [3:0] sec_ones;
    } mmss_t;

    localparam mmss_t MMSS_ZERO = '{min_tens: 3'd0, min_ones: 4'd0, sec_tens: 3'd0, sec_ones: 4'd0};
    localparam mmss_t MMSS_ONE  = '{min_tens: 3'd0, min_ones: 4'd0, sec_tens: 3'd0, sec_ones: 4'd1};
    localparam mmss_t MMSS_MAX  = '{min_tens: TENS_MAX, min_ones: ONES_MAX,
                                    sec_tens: TENS_MAX, sec_ones: ONES_MAX};

endpackage

// File: rtl/oven_bcd_time.sv
// mm:ss BCD time register with load-zero, add-N and sub-N operations that
// saturate at 59:59 and 00:00 instead of wrapping.
module oven_bcd_time
    import oven_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  bcd_op_t    op,
    input  logic [3:0] amount,
    output mmss_t      cur,
    output logic       is_zero
);

    logic [4:0] add_so;
    logic       add_cs;
    logic [2:0] add_st;
    logic       add_ct;
    logic [3:0] add_mo;
    logic       add_cm;
    logic [2:0] add_mt;
    mmss_t      sum;

    logic       sub_bs;
    logic [3:0] sub_so;
    logic       sub_bt;
    logic [2:0] sub_st;
    logic       sub_bm;
    logic [3:0] sub_mo;
    logic       sub_bu;
    mmss_t      diff;

    // Ripple the carry digit by digit; a carry out of the minute tens means overflow.
    always_comb begin
        add_so = 5'(cur.sec_ones) + 5'(amount);
        add_cs = add_so > 5'(ONES_MAX);
        add_st = cur.sec_tens + 3'(add_cs);
        add_ct = add_st > TENS_MAX;
        add_mo = cur.min_ones + 4'(add_ct);
        add_cm = add_mo > ONES_MAX;
        add_mt = cur.min_tens + 3'(add_cm);
        sum.sec_ones = add_cs ? 4'(add_so - 5'd10) : add_so[3:0];
        sum.sec_tens = add_ct ? 3'd0 : add_st;
        sum.min_ones = add_cm ? 4'd0 : add_mo;
        sum.min_tens = add_mt;
        if (add_mt > TENS_MAX) begin
            sum = MMSS_MAX;
        end
    end

    always_comb begin
        sub_bs = cur.sec_ones < amount;
        sub_so = sub_bs ? 4'(5'(cur.sec_ones) + 5'd10 - 5'(amount)) : cur.sec_ones - amount;
        sub_bt = cur.sec_tens < 3'(sub_bs);
        sub_st = sub_bt ? TENS_MAX : cur.sec_tens - 3'(sub_bs);
        sub_bm = cur.min_ones < 4'(sub_bt);
        sub_mo = sub_bm ? ONES_MAX : cur.min_ones - 4'(sub_bt);
        sub_bu = cur.min_tens < 3'(sub_bm);
        diff.sec_ones = sub_so;
        diff.sec_tens = sub_st;
        diff.min_ones = sub_mo;
        diff.min_tens = cur.min_tens - 3'(sub_bm);
        if (sub_bu) begin
            diff = MMSS_ZERO;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur <= MMSS_ZERO;
        end else begin
            case (op)
                OP_ZERO: cur <= MMSS_ZERO;
                OP_ADD:  cur <= sum;
                OP_SUB:  cur <= diff;
                default: cur <= cur;
            endcase
        end
    end

    assign is_zero = (cur == MMSS_ZERO);

endmodule

// File: rtl/oven_cook_ctrl.sv
// Oven cook-cycle controller: key/door synchronizers, set-key auto-repeat,
// the cook FSM with its one-second prescaler, heater gating and the beeper.
module oven_cook_ctrl
    import oven_pkg::*;
#(
    parameter int TICK_DIV   = 50000000,
    parameter int REPEAT_DIV = 10000000,
    parameter int STEP_SEC   = 5,
    parameter int BEEP_SEC   = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_up_n,
    input  logic       key_dn_n,
    input  logic       key_go_n,
    input  logic       key_stop_n,
    input  logic       door_open,
    output logic [3:0] sec_ones,
    output logic [2:0] sec_tens,
    output logic [3:0] min_ones,
    output logic [2:0] min_tens,
    output logic       heater_on,
    output logic       beep,
    output logic [2:0] state
);

    localparam int PRE_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int REP_W  = (REPEAT_DIV > 1) ? $clog2(REPEAT_DIV) : 1;
    localparam int BEEP_W = $clog2(BEEP_SEC) + 1;

    // Bit order {door, stop, go, dn, up}; all stages idle high (keys released).
    logic [4:0] sync1, sync2;
    logic [3:0] key_prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1    <= '1;
            sync2    <= '1;
            key_prev <= '1;
        end else begin
            sync1    <= {door_open, key_stop_n, key_go_n, key_dn_n, key_up_n};
            sync2    <= sync1;
            key_prev <= sync2[3:0];
        end
    end

    logic [3:0] press, held;
    logic       door_s;
    assign press  = key_prev & ~sync2[3:0];
    assign held   = ~sync2[3:0];
    assign door_s = sync2[4];

    logic up_press, dn_press, go_press, stop_press;
    assign up_press   = press[0];
    assign dn_press   = press[1];
    assign go_press   = press[2];
    assign stop_press = press[3];

    logic [REP_W-1:0] rep_cnt;
    logic             rep_tick, up_step, dn_step;

    assign rep_tick = (held[0] | held[1]) && !up_press && !dn_press
                      && (rep_cnt == REP_W'(REPEAT_DIV - 1));
    assign up_step  = up_press | (rep_tick & held[0]);
    assign dn_step  = dn_press | (rep_tick & held[1] & ~held[0]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rep_cnt <= '0;
        end else if (!(held[0] | held[1]) || up_press || dn_press || rep_tick) begin
            rep_cnt <= '0;
        end else begin
            rep_cnt <= rep_cnt + 1'b1;
        end
    end

    oven_state_t       st, st_n;
    logic [PRE_W-1:0]  pre, pre_n;
    logic [BEEP_W-1:0] beep_cnt, beep_cnt_n;
    bcd_op_t           op;
    logic [3:0]        amount;
    mmss_t             cur;
    logic              is_zero, tick, last_sec;

    assign tick     = (pre == PRE_W'(TICK_DIV - 1));
    assign last_sec = (cur == MMSS_ONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st       <= IDLE;
            pre      <= '0;
            beep_cnt <= '0;
        end else begin
            st       <= st_n;
            pre      <= pre_n;
            beep_cnt <= beep_cnt_n;
        end
    end

    always_comb begin
        st_n       = st;
        pre_n      = pre;
        beep_cnt_n = beep_cnt;
        op         = OP_HOLD;
        amount     = 4'(STEP_SEC);
        case (st)
            IDLE: begin
                pre_n = '0;
                if (stop_press) begin
                    op = OP_ZERO;
                end else if (go_press) begin
                    if (!is_zero && !door_s) st_n = COOK;
                end else if (up_step) begin
                    op = OP_ADD;
                end else if (dn_step) begin
                    op = OP_SUB;
                end
            end
            COOK: begin
                // The final tick beats a coincident door-open or stop.
                if (tick && last_sec) begin
                    op         = OP_SUB;
                    amount     = 4'd1;
                    pre_n      = '0;
                    beep_cnt_n = '0;
                    st_n       = DONE;
                end else if (stop_press || door_s) begin
                    st_n = PAUSE;
                end else if (tick) begin
                    op     = OP_SUB;
                    amount = 4'd1;
                    pre_n  = '0;
                end else begin
                    pre_n = pre + 1'b1;
                end
            end
            PAUSE: begin
                if (stop_press) begin
                    op    = OP_ZERO;
                    pre_n = '0;
                    st_n  = IDLE;
                end else if (go_press && !door_s) begin
                    st_n = COOK;
                end
            end
            DONE: begin
                if (|press) begin
                    pre_n = '0;
                    st_n  = IDLE;
                end else if (tick) begin
                    pre_n = '0;
                    if (beep_cnt == BEEP_W'(BEEP_SEC - 1)) st_n = IDLE;
                    else beep_cnt_n = beep_cnt + 1'b1;
                end else begin
                    pre_n = pre + 1'b1;
                end
            end
            default: begin
                pre_n = '0;
                st_n  = IDLE;
            end
        endcase
    end

    oven_bcd_time u_time (
        .clk     (clk),
        .rst     (rst),
        .op      (op),
        .amount  (amount),
        .cur     (cur),
        .is_zero (is_zero)
    );

    assign sec_ones  = cur.sec_ones;
    assign sec_tens  = cur.sec_tens;
    assign min_ones  = cur.min_ones;
    assign min_tens  = cur.min_tens;
    assign heater_on = (st == COOK) && !door_s;
    assign beep      = (st == DONE);
    assign state     = st;

endmodule
